// File: rtl/nbiot_ul_pkg.sv
// Shared constants and types for the NB-IoT uplink resource-element mapper.
// One slot is NUM_SYM SC-FDMA symbols of NUM_SC subcarriers. PILOT_SYM is the
// DMRS symbol, which carries pilot REs instead of upstream data.
package nbiot_ul_pkg;

    localparam int NUM_SC  = 12;
    localparam int NUM_SYM = 7;

    localparam logic [2:0] PILOT_SYM = 3'b100;

    // Counter boundary values in the widths the counters use.
    localparam logic [3:0] SC_FIRST  = 4'd0;
    localparam logic [3:0] SC_LAST   = 4'(NUM_SC - 1);
    localparam logic [2:0] SYM_FIRST = 3'd1;
    localparam logic [2:0] SYM_LAST  = 3'(NUM_SYM);

    // The binary encoding is explicit so state codes are the same in every tool.
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        MAP_DATA  = 2'b01,
        MAP_PILOT = 2'b10,
        DONE      = 2'b11
    } map_state_t;

    // Returns 1 when the given symbol number is the DMRS symbol.
    function automatic logic is_pilot_sym(input logic [2:0] sym);
        return sym == PILOT_SYM;
    endfunction

    // Symbol number that follows the given one, wrapping 7 -> 1.
    function automatic logic [2:0] next_sym(input logic [2:0] sym);
        return (sym == SYM_LAST) ? SYM_FIRST : 3'(sym + 3'd1);
    endfunction

endpackage

// File: rtl/re_map_ctrl_if.sv
// Handshake and status bundle between the RE mapper, the upstream modulator
// and the downstream IFFT loader. The mapper uses the slave modport; whatever
// drives the run (or a testbench) uses the master modport.
interface re_map_ctrl_if;

    // Run control
    logic       i_start;
    logic [3:0] i_num_slots;

    // Upstream data symbols
    logic       i_data_valid;
    logic       o_data_ready;

    // Downstream resource elements
    logic       i_out_ready;
    logic       o_valid;
    logic [3:0] o_sc_indx;
    logic [2:0] o_sym_num;
    logic       o_pilot;

    // Progress and status
    logic       o_sym_done;
    logic       o_slot_done;
    logic       o_busy;
    logic       o_done;

    modport slave (
        input  i_start,
        input  i_num_slots,
        input  i_data_valid,
        input  i_out_ready,
        output o_data_ready,
        output o_valid,
        output o_sc_indx,
        output o_sym_num,
        output o_pilot,
        output o_sym_done,
        output o_slot_done,
        output o_busy,
        output o_done
    );

    modport master (
        output i_start,
        output i_num_slots,
        output i_data_valid,
        output i_out_ready,
        input  o_data_ready,
        input  o_valid,
        input  o_sc_indx,
        input  o_sym_num,
        input  o_pilot,
        input  o_sym_done,
        input  o_slot_done,
        input  o_busy,
        input  o_done
    );

endinterface

// File: rtl/re_map_cnt.sv
// Subcarrier / symbol / slot counter chain for the RE mapper.
// sc steps on every enabled cycle. It wraps 11 -> 0 and carries into sym.
// sym wraps 7 -> 1 and carries into slot. The wrap flags are qualified by
// en, so they are valid only on the cycle whose transfer causes the wrap.
// clear loads the start-of-run values and takes priority over en.
module re_map_cnt
    import nbiot_ul_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    output logic [3:0] sc,
    output logic [2:0] sym,
    output logic [3:0] slot,
    output logic       sym_wrap,
    output logic       slot_wrap
);

    // Wrap flags: the last subcarrier of a symbol, and of the last symbol of a slot.
    assign sym_wrap  = en && (sc == SC_LAST);
    assign slot_wrap = sym_wrap && (sym == SYM_LAST);

    // Counter chain: start-of-run load, then advance on each transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so that every
            // register samples the pre-edge values, whatever order the statements are in.
            sc   <= SC_FIRST;
            sym  <= SYM_FIRST;
            slot <= 4'd0;
        end else if (clear) begin
            sc   <= SC_FIRST;
            sym  <= SYM_FIRST;
            slot <= 4'd0;
        end else if (en) begin
            if (sc == SC_LAST) begin
                sc  <= SC_FIRST;
                sym <= next_sym(sym);
                if (sym == SYM_LAST) begin
                    slot <= slot + 4'd1;
                end
            end else begin
                sc <= sc + 4'd1;
            end
        end
    end

endmodule

// File: rtl/re_map_ctrl.sv
// Resource-element mapper controller for the NB-IoT uplink.
// It walks subcarriers 0..11 of symbols 1..7 for i_num_slots slots and
// presents one RE per transfer to the IFFT loader. Symbol 4 is filled from
// the DMRS pilot source; every other symbol passes upstream data through.
// Handshake outputs are combinational from state and the live handshake
// inputs. Position outputs come straight from the registered counters, so
// they hold while downstream stalls.
module re_map_ctrl
    import nbiot_ul_pkg::*;
(
    input  logic          i_clk_map,
    input  logic          i_rst_n,
    re_map_ctrl_if.slave  bus
);

    map_state_t state;
    map_state_t state_nxt;

    logic [3:0] num_slots_q;
    logic       start_ok;
    logic       cnt_clear;
    logic       xfer;

    logic       valid;
    logic       data_ready;
    logic       pilot;

    logic [3:0] sc;
    logic [2:0] sym;
    logic [3:0] slot;
    logic       sym_wrap;
    logic       slot_wrap;
    logic       last_slot;

    // A start is accepted only from IDLE and only for a non-empty run.
    assign start_ok  = bus.i_start && (state == IDLE) && (bus.i_num_slots != 4'd0);
    assign cnt_clear = start_ok;

    // num_slots_q cannot be zero during a run, so the subtraction cannot underflow.
    assign last_slot = slot_wrap && (slot == (num_slots_q - 4'd1));

    // Datapath outputs decoded from state. The data path is pass-through, so
    // valid and ready follow the handshake inputs in the same cycle.
    assign valid      = ((state == MAP_DATA) && bus.i_data_valid) || (state == MAP_PILOT);
    assign data_ready = (state == MAP_DATA) && bus.i_out_ready;
    assign pilot      = (state == MAP_PILOT);
    assign xfer       = valid && bus.i_out_ready;

    re_map_cnt u_cnt (
        .clk       (i_clk_map),
        .rst_n     (i_rst_n),
        .clear     (cnt_clear),
        .en        (xfer),
        .sc        (sc),
        .sym       (sym),
        .slot      (slot),
        .sym_wrap  (sym_wrap),
        .slot_wrap (slot_wrap)
    );

    // State register and the slot count latched when a run is accepted.
    always_ff @(posedge i_clk_map or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            num_slots_q <= 4'd0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                num_slots_q <= bus.i_num_slots;
            end
        end
    end

    // Next-state logic. Symbol boundaries are taken on the wrapping transfer,
    // so the new state lines up with the new symbol number.
    always_comb begin
        // NOTE: the default comes first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = MAP_DATA;
                end
            end
            MAP_DATA: begin
                if (last_slot) begin
                    state_nxt = DONE;
                end else if (sym_wrap && is_pilot_sym(next_sym(sym))) begin
                    state_nxt = MAP_PILOT;
                end
            end
            MAP_PILOT: begin
                // The pilot symbol is never the last symbol of a slot.
                if (sym_wrap) begin
                    state_nxt = MAP_DATA;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs to the bus.
    assign bus.o_valid      = valid;
    assign bus.o_data_ready = data_ready;
    assign bus.o_pilot      = pilot;
    assign bus.o_sc_indx    = sc;
    assign bus.o_sym_num    = sym;
    assign bus.o_sym_done   = sym_wrap;
    assign bus.o_slot_done  = slot_wrap;
    assign bus.o_busy       = (state != IDLE);
    assign bus.o_done       = (state == DONE);

endmodule
